// File: rtl/memory.sv
// memory: 256-word RAM with two captured input ports and one output port,
// all sharing a single byte-addressed map. Read data is registered (one
// cycle of latency) and reads of any mapped location return the value held
// before the clock edge, including on a simultaneous write or port capture.
//
// Address map (byte addresses):
//   address[WIDTH-1:10] == 0 : RAM, word index address[9:2]
//   0x0000FFF8              : INPORT0 (read only, writes ignored)
//   0x0000FFFC              : PORT1 (read returns inport1, write loads outport)
//   anything else           : unmapped, reads return 0, writes ignored
//
// Build option: define MEMORY_INPORT_RESET_EN to make rst also clear both
// input-port registers. Without it the input ports keep their value across
// reset, because they mirror external pins rather than internal state.
module memory #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] address,
  input  logic [WIDTH-1:0] in_data,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             inport_0_en,
  input  logic             inport_1_en,
  input  logic             mem_write,
  output logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] outport
);

  localparam int DEPTH  = 256;
  localparam int AW     = 8;

  localparam logic [WIDTH-1:0] INPORT0_ADDR = WIDTH'(32'h0000_FFF8);
  localparam logic [WIDTH-1:0] PORT1_ADDR   = WIDTH'(32'h0000_FFFC);

  // Decode classes; also used as the registered read-source select.
  localparam logic [1:0] DEC_UNMAPPED = 2'd0;
  localparam logic [1:0] DEC_RAM      = 2'd1;
  localparam logic [1:0] DEC_INPORT0  = 2'd2;
  localparam logic [1:0] DEC_PORT1    = 2'd3;

  logic [WIDTH-1:0] ram_q [DEPTH];
  logic [WIDTH-1:0] ram_rdata_q;
  logic [WIDTH-1:0] inport0_q;
  logic [WIDTH-1:0] inport1_q;
  logic [WIDTH-1:0] port_rdata_q;
  logic [WIDTH-1:0] outport_q;
  logic [1:0]       rd_sel_q;

  logic [1:0]       dec;
  logic [AW-1:0]    word_idx;
  logic             ram_we;
  logic             outport_we;
  logic [WIDTH-1:0] port_rdata_d;

  assign word_idx = address[9:2];

  // Classify the current address into one of the four map regions.
  always_comb begin
    dec = DEC_UNMAPPED;
    if (address[WIDTH-1:10] == '0) begin
      dec = DEC_RAM;
    end else if (address == INPORT0_ADDR) begin
      dec = DEC_INPORT0;
    end else if (address == PORT1_ADDR) begin
      dec = DEC_PORT1;
    end
  end

  // Reset blocks every write in its cycle so no state moves while rst is high.
  assign ram_we     = mem_write && (dec == DEC_RAM) && !rst;
  assign outport_we = mem_write && (dec == DEC_PORT1) && !rst;

  // RAM with registered read; non-blocking ordering gives read-before-write.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram_q[word_idx] <= wr_data;
    end
    ram_rdata_q <= ram_q[word_idx];
  end

  // Input-port capture registers; enables ignore address and mem_write.
  always_ff @(posedge clk) begin
`ifdef MEMORY_INPORT_RESET_EN
    if (rst) begin
      inport0_q <= '0;
      inport1_q <= '0;
    end else begin
      if (inport_0_en) inport0_q <= in_data;
      if (inport_1_en) inport1_q <= in_data;
    end
`else
    if (inport_0_en) inport0_q <= in_data;
    if (inport_1_en) inport1_q <= in_data;
`endif
  end

  // Pick which input port a read would see, using pre-capture values.
  always_comb begin
    port_rdata_d = inport1_q;
    if (dec == DEC_INPORT0) begin
      port_rdata_d = inport0_q;
    end
  end

  // Snapshot the addressed input port alongside the RAM read.
  always_ff @(posedge clk) begin
    port_rdata_q <= port_rdata_d;
  end

  // Remember the read source; reset forces the unmapped path so rd_data is 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_sel_q <= DEC_UNMAPPED;
    end else begin
      rd_sel_q <= dec;
    end
  end

  // Output port register, loaded only by writes to PORT1.
  always_ff @(posedge clk) begin
    if (rst) begin
      outport_q <= '0;
    end else if (outport_we) begin
      outport_q <= wr_data;
    end
  end

  // Final read mux over already-registered sources (still one-cycle latency).
  always_comb begin
    rd_data = '0;
    case (rd_sel_q)
      DEC_RAM:      rd_data = ram_rdata_q;
      DEC_INPORT0:  rd_data = port_rdata_q;
      DEC_PORT1:    rd_data = port_rdata_q;
      default:      rd_data = '0;
    endcase
  end

  assign outport = outport_q;

endmodule

// File: tb/tb_memory.sv
// tb_memory: directed test of the memory block. Inputs change on the falling
// edge; outputs are sampled 1 time unit after the rising edge.
module tb_memory;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [WIDTH-1:0] address = '0;
  logic [WIDTH-1:0] in_data = '0;
  logic [WIDTH-1:0] wr_data = '0;
  logic             inport_0_en = 1'b0;
  logic             inport_1_en = 1'b0;
  logic             mem_write = 1'b0;
  logic [WIDTH-1:0] rd_data;
  logic [WIDTH-1:0] outport;

  int vectors = 0;
  int miscompares = 0;
  logic [WIDTH-1:0] exp_inport0_after_rst;

  memory #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .address     (address),
    .in_data     (in_data),
    .wr_data     (wr_data),
    .inport_0_en (inport_0_en),
    .inport_1_en (inport_1_en),
    .mem_write   (mem_write),
    .rd_data     (rd_data),
    .outport     (outport)
  );

  always #5 clk = ~clk;

  // Apply one cycle of inputs at the falling edge, then wait past the rising edge.
  task automatic step(input logic r, input logic [WIDTH-1:0] a, input logic we,
                      input logic [WIDTH-1:0] wd, input logic e0, input logic e1,
                      input logic [WIDTH-1:0] id);
    @(negedge clk);
    rst = r; address = a; mem_write = we; wr_data = wd;
    inport_0_en = e0; inport_1_en = e1; in_data = id;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    vectors++;
    assert (obs === exp)
      $display("vector %0d %s: observed=%h expected=%h ok", vectors, tag, obs, exp);
    else begin
      miscompares++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
`ifdef MEMORY_INPORT_RESET_EN
    exp_inport0_after_rst = 32'h0000_0000;
`else
    exp_inport0_after_rst = 32'h0001_0000;
`endif

    // Reset state
    step(1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("reset_rd_data", rd_data, 32'h0);
    chk("reset_outport", outport, 32'h0);

    // RAM writes then reads, including ignored low address bits
    step(1'b0, 32'h0, 1'b1, 32'h0A0A_0A0A, 1'b0, 1'b0, 32'h0);
    step(1'b0, 32'h4, 1'b1, 32'hF0F0_F0F0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("read_0", rd_data, 32'h0A0A_0A0A);
    step(1'b0, 32'h4, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("read_4", rd_data, 32'hF0F0_F0F0);
    step(1'b0, 32'h1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("read_1", rd_data, 32'h0A0A_0A0A);
    step(1'b0, 32'h5, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("read_5", rd_data, 32'hF0F0_F0F0);

    // Outport write leaves RAM alone
    step(1'b0, 32'hFFFC, 1'b1, 32'h0000_1111, 1'b0, 1'b0, 32'h0);
    chk("outport_write", outport, 32'h0000_1111);
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("ram0_after_outport", rd_data, 32'h0A0A_0A0A);
    step(1'b0, 32'h4, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("ram1_after_outport", rd_data, 32'hF0F0_F0F0);

    // Both enables load both input ports
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_ABCD);
    step(1'b0, 32'hFFF8, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("both_en_inport0", rd_data, 32'h0000_ABCD);
    step(1'b0, 32'hFFFC, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("both_en_inport1", rd_data, 32'h0000_ABCD);

    // Capture coinciding with a read returns the old inport value
    step(1'b0, 32'hFFF8, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0001_0000);
    chk("inport0_capture_old", rd_data, 32'h0000_ABCD);
    step(1'b0, 32'hFFF8, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("inport0_new", rd_data, 32'h0001_0000);
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0001);
    step(1'b0, 32'hFFFC, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("inport1_read", rd_data, 32'h0000_0001);
    chk("outport_not_inport", outport, 32'h0000_1111);

    // Reset with a pending outport write: rst wins
    step(1'b1, 32'hFFFC, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
    chk("rst_outport", outport, 32'h0);
    chk("rst_rd_data", rd_data, 32'h0);
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("ram0_after_rst", rd_data, 32'h0A0A_0A0A);
    step(1'b0, 32'hFFF8, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("inport0_after_rst", rd_data, exp_inport0_after_rst);
    chk("outport_after_rst", outport, 32'h0);

    // Same-cycle RAM read/write returns old word
    step(1'b0, 32'h8, 1'b1, 32'h55AA_55AA, 1'b0, 1'b0, 32'h0);
    step(1'b0, 32'h8, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 32'h0);
    chk("rw_same_cycle_old", rd_data, 32'h55AA_55AA);
    step(1'b0, 32'h8, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("rw_next_read", rd_data, 32'h1234_5678);

    // Writes to INPORT0 and unmapped space are dropped
    step(1'b0, 32'hFFF8, 1'b1, 32'h0000_0999, 1'b0, 1'b0, 32'h0);
    step(1'b0, 32'hFFF8, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("inport0_write_ignored", rd_data, exp_inport0_after_rst);
    step(1'b0, 32'h2000, 1'b1, 32'h0000_0777, 1'b0, 1'b0, 32'h0);
    step(1'b0, 32'h2000, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("unmapped_read_zero", rd_data, 32'h0);
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("ram0_no_alias_write", rd_data, 32'h0A0A_0A0A);
    chk("outport_unchanged", outport, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/memory.md
MEMORY -- requirements
Module: memory

Interface
REQ-001 SHALL provide parameter: WIDTH, 32, data/address width in bits.
REQ-002 SHALL have port: clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port: rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port: address  input  WIDTH  byte address for read/write/IO decode.
REQ-005 SHALL have port: in_data  input  WIDTH  data for the input-port registers.
REQ-006 SHALL have port: wr_data  input  WIDTH  write data for RAM or outport.
REQ-007 SHALL have port: inport_0_en  input  1  capture in_data into inport0.
REQ-008 SHALL have port: inport_1_en  input  1  capture in_data into inport1.
REQ-009 SHALL have port: mem_write  input  1  write strobe.
REQ-010 SHALL have port: rd_data  output  WIDTH  registered read data.
REQ-011 SHALL have port: outport  output  WIDTH  registered output-port value.

Function
REQ-012 SHALL contain 256 x WIDTH-bit RAM, word-addressed by address[9:2]; address[1:0] ignored (address 1 reads word 0, address 5 reads word 1).
REQ-013 SHALL decode: RAM when address[WIDTH-1:10]==0; INPORT0 when address==0x0000FFF8; PORT1 when address==0x0000FFFC; all else UNMAPPED.
REQ-014 SHALL write RAM[address[9:2]] <= wr_data at rising edge when mem_write=1 and decode=RAM.
REQ-015 SHALL load outport <= wr_data at rising edge when mem_write=1 and decode=PORT1.
REQ-016 SHALL ignore writes to INPORT0 and UNMAPPED addresses (no state change).
REQ-017 SHALL capture inport0 <= in_data at rising edge when inport_0_en=1, and inport1 likewise with inport_1_en; both enables high loads both; enables independent of address and mem_write.
REQ-018 SHALL update rd_data every rising edge (1-cycle latency): RAM word for RAM, inport0 for INPORT0, inport1 for PORT1, 0 for UNMAPPED; regardless of mem_write.
REQ-019 SHALL return pre-write (old) contents when RAM is read and written at the same address in the same cycle.
REQ-020 SHALL return the inport value held before the edge when a capture and a read of that port coincide.
REQ-021 SHALL never drive outport from inport values; reads of 0xFFFC return inport1, not outport.

Reset
REQ-022 SHALL, on rising edge with rst=1, set rd_data=0 and outport=0; rst dominates mem_write and reads in that cycle.
REQ-023 SHALL NOT clear RAM contents on reset; contents are undefined after power-up.
REQ-024 SHALL resume normal operation on the first rising edge with rst=0.

Configuration
REQ-025 SHALL support macro MEMORY_INPORT_RESET_EN: when defined, rst also clears inport0 and inport1 to 0 (rst dominates enables); when undefined, inport registers are not reset and retain values across rst.

Verification
REQ-026 Write 0x0A0A0A0A @0, 0xF0F0F0F0 @4; read @0 -> rd_data=0x0A0A0A0A one edge later; read @4 -> 0xF0F0F0F0.
REQ-027 Read @1 -> 0x0A0A0A0A; read @5 -> 0xF0F0F0F0 (low address bits ignored).
REQ-028 mem_write=1, address=0xFFFC, wr_data=0x00001111 -> outport=0x00001111 after edge; RAM words 0 and 1 unchanged.
REQ-029 inport_0_en=1, in_data=0x00010000, then read 0xFFF8 -> 0x00010000; inport_1_en=1, in_data=1, read 0xFFFC -> 0x00000001; outport stays 0x00001111.
REQ-030 rst=1 for one edge after REQ-028 -> outport=0, rd_data=0; read @0 after -> still 0x0A0A0A0A; with MEMORY_INPORT_RESET_EN, read 0xFFF8 -> 0, without -> 0x00010000.
REQ-031 Same-cycle write 0x12345678 and read @8 -> rd_data shows old word; next read @8 -> 0x12345678; write to 0xFFF8 or 0x2000 -> no change, read 0x2000 -> 0.
